// File: rtl/vga_pkg.sv
// Shared VGA constants: resolutions, derived field widths and the scanner state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

   // 320x240 frame buffer
   localparam int H_RES_320  = 320;
   localparam int V_RES_240  = 240;
   localparam int X_W_320    = 9;
   localparam int Y_W_240    = 8;
   localparam int ADDR_W_320 = 17;

   // 640x480 frame buffer
   localparam int H_RES_640  = 640;
   localparam int V_RES_480  = 480;
   localparam int X_W_640    = 10;
   localparam int Y_W_480    = 9;
   localparam int ADDR_W_640 = 19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage

// File: rtl/vga_rect_clip.sv
// Clips a requested rectangle's width/height to the visible screen area.
// Latency: purely combinational.
// Backpressure: none; inputs are already-latched request fields.
module vga_rect_clip #(
   parameter int H_RES = 320,
   parameter int V_RES = 240,
   parameter int X_W   = 9,
   parameter int Y_W   = 8
) (
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   output logic [X_W-1:0] w_eff,
   output logic [Y_W-1:0] h_eff
);

   localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
   localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

   logic [X_W:0] x_room;
   logic [Y_W:0] y_room;

   // Width shrinks to the columns left of the right edge; an off-screen origin yields zero.
   always_comb begin
      x_room = H_LIM - {1'b0, x0};
      w_eff  = w;
      if ({1'b0, x0} >= H_LIM) begin
         w_eff = '0;
      end else if ({1'b0, w} > x_room) begin
         w_eff = x_room[X_W-1:0];
      end
   end

   // Height shrinks to the lines above the bottom edge; an off-screen origin yields zero.
   always_comb begin
      y_room = V_LIM - {1'b0, y0};
      h_eff  = h;
      if ({1'b0, y0} >= V_LIM) begin
         h_eff = '0;
      end else if ({1'b0, h} > y_room) begin
         h_eff = y_room[Y_W-1:0];
      end
   end

endmodule

// File: rtl/vga_rect_address_scanner.sv
// Raster-scans a rectangle, emitting x/y/linear address/last per pixel; optional clip via VGA_RECT_CLIP_EN.
// Latency: first beat 2 cycles after accept, then 1 pixel/cycle; done pulses the cycle after the last beat.
// Backpressure: pix_* hold while pix_valid && !pix_ready; start_ready only in IDLE, requests never queued.
module vga_rect_address_scanner
   import vga_pkg::*;
#(
   parameter int H_RES  = H_RES_320,
   parameter int V_RES  = V_RES_240,
   parameter int X_W    = X_W_320,
   parameter int Y_W    = Y_W_240,
   parameter int ADDR_W = ADDR_W_320
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [X_W-1:0]    x0,
   input  logic [Y_W-1:0]    y0,
   input  logic [X_W-1:0]    w,
   input  logic [Y_W-1:0]    h,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [X_W-1:0]    pix_x,
   output logic [Y_W-1:0]    pix_y,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam logic [X_W:0]      X_ONE  = {{X_W{1'b0}}, 1'b1};
   localparam logic [Y_W:0]      Y_ONE  = {{Y_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

   scan_state_t       state_q, state_d;
   logic [X_W-1:0]    x0_q, x0_d, w_q, w_d;
   logic [Y_W-1:0]    y0_q, y0_d, h_q, h_d;
   // Column/row counters and end bounds carry one extra bit so an oversized
   // unclipped rectangle still terminates instead of wrapping forever.
   logic [X_W:0]      x_end_q, x_end_d, cx_q, cx_d;
   logic [Y_W:0]      y_end_q, y_end_d, cy_q, cy_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
   logic              valid_q, valid_d, last_q, last_d;

   logic [X_W-1:0]    w_eff;
   logic [Y_W-1:0]    h_eff;
   logic [ADDR_W-1:0] row_base_load;

`ifdef VGA_RECT_CLIP_EN
   vga_rect_clip #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) u_clip (
      .x0    (x0_q),
      .y0    (y0_q),
      .w     (w_q),
      .h     (h_q),
      .w_eff (w_eff),
      .h_eff (h_eff)
   );
`else
   assign w_eff = w_q;
   assign h_eff = h_q;
`endif

   // Only multiply in the design: one constant multiply per rectangle, rows then step by H_RES.
   assign row_base_load = ADDR_W'(y0_q) * H_STEP;

   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign pix_valid   = valid_q;
   assign pix_last    = last_q;
   assign pix_x       = cx_q[X_W-1:0];
   assign pix_y       = cy_q[Y_W-1:0];
   assign pix_addr    = addr_q;

   // Next-state and counter update: latch request, set up bounds, then walk the raster.
   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      row_base_d = row_base_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      last_d     = last_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               x0_d    = x0;
               y0_d    = y0;
               w_d     = w;
               h_d     = h;
               state_d = LOAD;
            end
         end
         LOAD: begin
            x_end_d    = {1'b0, x0_q} + {1'b0, w_eff} - X_ONE;
            y_end_d    = {1'b0, y0_q} + {1'b0, h_eff} - Y_ONE;
            row_base_d = row_base_load;
            if ((w_eff == '0) || (h_eff == '0)) begin
               state_d = DONE;
            end else begin
               cx_d    = {1'b0, x0_q};
               cy_d    = {1'b0, y0_q};
               addr_d  = row_base_load + ADDR_W'(x0_q);
               valid_d = 1'b1;
               last_d  = (x_end_d == {1'b0, x0_q}) && (y_end_d == {1'b0, y0_q});
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (valid_q && pix_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = DONE;
               end else if (cx_q != x_end_q) begin
                  cx_d   = cx_q + X_ONE;
                  addr_d = addr_q + A_ONE;
                  last_d = (cx_d == x_end_q) && (cy_q == y_end_q);
               end else begin
                  cx_d       = {1'b0, x0_q};
                  cy_d       = cy_q + Y_ONE;
                  row_base_d = row_base_q + H_STEP;
                  addr_d     = row_base_d + ADDR_W'(x0_q);
                  last_d     = (cx_d == x_end_q) && (cy_d == y_end_q);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any rectangle in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
      end
   end

endmodule

// File: tb/tb_vga_rect_address_scanner.sv
// Scoreboard bench: requests push expected pixels from a raster model; a negedge monitor pops and compares.
// Latency: checks first beat / done timing against the accept edge and last beat.
// Backpressure: pix_ready driven always-on, 1-0-0 pattern, or random.
module tb_vga_rect_address_scanner;
   import vga_pkg::*;

   localparam int H  = H_RES_320;
   localparam int V  = V_RES_240;
   localparam int XW = X_W_320;
   localparam int YW = Y_W_240;
   localparam int AW = ADDR_W_320;

   typedef struct {
      int x;
      int y;
      int addr;
      bit last;
   } beat_t;

   typedef struct {
      int start;
      int npix;
   } req_t;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [XW-1:0] x0_i = '0;
   logic [YW-1:0] y0_i = '0;
   logic [XW-1:0] w_i  = '0;
   logic [YW-1:0] h_i  = '0;
   logic          pix_valid;
   logic          pix_ready = 1'b1;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [AW-1:0] pix_addr;
   logic          pix_last;
   logic          busy;
   logic          done;

   vga_rect_address_scanner dut (
      .clock       (clock),
      .resetn      (resetn),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .x0          (x0_i),
      .y0          (y0_i),
      .w           (w_i),
      .h           (h_i),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_addr    (pix_addr),
      .pix_last    (pix_last),
      .busy        (busy),
      .done        (done)
   );

   // 640x480 instance for the far-corner single-pixel case
   logic                  b_start_valid = 1'b0;
   logic                  b_start_ready;
   logic [X_W_640-1:0]    b_x0 = '0;
   logic [Y_W_480-1:0]    b_y0 = '0;
   logic [X_W_640-1:0]    b_w  = '0;
   logic [Y_W_480-1:0]    b_h  = '0;
   logic                  b_pix_valid;
   logic [X_W_640-1:0]    b_pix_x;
   logic [Y_W_480-1:0]    b_pix_y;
   logic [ADDR_W_640-1:0] b_pix_addr;
   logic                  b_pix_last;
   logic                  b_busy;
   logic                  b_done;

   vga_rect_address_scanner #(
      .H_RES  (H_RES_640),
      .V_RES  (V_RES_480),
      .X_W    (X_W_640),
      .Y_W    (Y_W_480),
      .ADDR_W (ADDR_W_640)
   ) dut_b (
      .clock       (clock),
      .resetn      (resetn),
      .start_valid (b_start_valid),
      .start_ready (b_start_ready),
      .x0          (b_x0),
      .y0          (b_y0),
      .w           (b_w),
      .h           (b_h),
      .pix_valid   (b_pix_valid),
      .pix_ready   (1'b1),
      .pix_x       (b_pix_x),
      .pix_y       (b_pix_y),
      .pix_addr    (b_pix_addr),
      .pix_last    (b_pix_last),
      .busy        (b_busy),
      .done        (b_done)
   );

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    rmode = 0;
   int    pat   = 0;
   beat_t exp_q[$];
   req_t  req_q[$];

   bit    mon_active = 1'b0;
   int    beats_left = 0;
   int    exp_done   = -1;
   int    ready_chk  = -1;
   bit    stall_prev = 1'b0;
   logic [XW-1:0] prev_x;
   logic [YW-1:0] prev_y;
   logic [AW-1:0] prev_addr;
   logic          prev_last;
   beat_t mb;
   req_t  mr;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: every pixel of the (optionally clipped) rectangle in raster order.
   function automatic int model_push(input int x0, input int y0, input int w, input int h);
      int    we = w;
      int    he = h;
      beat_t b;
`ifdef VGA_RECT_CLIP_EN
      if (x0 >= H) we = 0; else if (w > H - x0) we = H - x0;
      if (y0 >= V) he = 0; else if (h > V - y0) he = V - y0;
`endif
      for (int yy = 0; yy < he; yy++) begin
         for (int xx = 0; xx < we; xx++) begin
            b.x    = (x0 + xx) % (1 << XW);
            b.y    = (y0 + yy) % (1 << YW);
            b.addr = ((y0 + yy) * H + x0 + xx) % (1 << AW);
            b.last = (xx == we - 1) && (yy == he - 1);
            exp_q.push_back(b);
         end
      end
      return we * he;
   endfunction

   // Consumer ready generator
   always @(posedge clock) begin
      #1;
      case (rmode)
         0: pix_ready = 1'b1;
         1: begin
            pix_ready = (pat == 0);
            pat = (pat + 1) % 3;
         end
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops the scoreboard on every transfer, checks stall stability and done timing.
   always @(negedge clock) begin
      if (resetn) begin
         if (ready_chk == cyc) check("start_ready_after_done", int'(start_ready), 1);
         if (stall_prev) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_x", int'(pix_x), int'(prev_x));
            check("stall_y", int'(pix_y), int'(prev_y));
            check("stall_addr", int'(pix_addr), int'(prev_addr));
            check("stall_last", int'(pix_last), int'(prev_last));
         end
         if (pix_valid) begin
            if (!mon_active) begin
               if (req_q.size() == 0) begin
                  check("beat_without_request", 1, 0);
               end else begin
                  mr = req_q.pop_front();
                  check("first_beat_latency", cyc, mr.start + 1);
                  mon_active = 1'b1;
                  beats_left = mr.npix;
               end
            end
            if (pix_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat_addr", int'(pix_addr), -1);
               end else begin
                  mb = exp_q.pop_front();
                  check("pix_x", int'(pix_x), mb.x);
                  check("pix_y", int'(pix_y), mb.y);
                  check("pix_addr", int'(pix_addr), mb.addr);
                  check("pix_last", int'(pix_last), int'(mb.last));
                  beats_left--;
                  if (beats_left == 0) exp_done = cyc + 1;
               end
            end
         end
         if (done) begin
            if (mon_active && beats_left == 0) begin
               check("done_after_last", cyc, exp_done);
               mon_active = 1'b0;
            end else if (!mon_active && req_q.size() != 0 && req_q[0].npix == 0) begin
               mr = req_q.pop_front();
               check("done_empty_latency", cyc, mr.start + 1);
            end else begin
               check("unexpected_done", 1, 0);
            end
            ready_chk = cyc + 1;
         end
         stall_prev = pix_valid && !pix_ready;
         prev_x     = pix_x;
         prev_y     = pix_y;
         prev_addr  = pix_addr;
         prev_last  = pix_last;
      end
   end

   task automatic send(input int x0, input int y0, input int w, input int h);
      bit ok = 1'b0;
      int n;
      for (int i = 0; i < 500; i++) begin
         @(posedge clock);
         #1;
         if (start_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("start_ready_timeout", 0, 1);
      end else begin
         start_valid = 1'b1;
         x0_i = XW'(x0);
         y0_i = YW'(y0);
         w_i  = XW'(w);
         h_i  = YW'(h);
         n = model_push(x0, y0, w, h);
         req_q.push_back('{start: cyc + 1, npix: n});
         @(posedge clock);
         #1;
         start_valid = 1'b0;
         check("busy_after_accept", int'(busy), 1);
         check("start_ready_after_accept", int'(start_ready), 0);
         // scramble inputs: they must only be sampled on the accept cycle
         x0_i = XW'($urandom);
         y0_i = YW'($urandom);
         w_i  = XW'($urandom);
         h_i  = YW'($urandom);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         if (start_ready && exp_q.size() == 0 && req_q.size() == 0 && !mon_active) return;
      end
      check("idle_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, int'(start_ready), 1);
      check({tag, "_pix_valid"}, int'(pix_valid), 0);
      check({tag, "_pix_last"}, int'(pix_last), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pix_x"}, int'(pix_x), 0);
      check({tag, "_pix_y"}, int'(pix_y), 0);
      check({tag, "_pix_addr"}, int'(pix_addr), 0);
   endtask

   initial begin
      int rx, ry, rw, rh, nb, nd;
      bit ok;
      #12;
      check_reset_outputs("reset");
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // directed: 3x2 at (10,2), continuous ready
      rmode = 0;
      send(10, 2, 3, 2);
      wait_idle();
      // same rectangle with 1,0,0 ready pattern
      rmode = 1;
      pat   = 0;
      send(10, 2, 3, 2);
      wait_idle();
      // zero width
      rmode = 0;
      send(20, 20, 0, 5);
      wait_idle();
      // bottom-right corner, exact fit and oversize
      send(318, 239, 2, 1);
      wait_idle();
      send(318, 239, 4, 1);
      wait_idle();

      // randomized on-screen rectangles with random backpressure
      rmode = 2;
      for (int k = 0; k < 30; k++) begin
         rx = $urandom_range(0, H - 1);
         ry = $urandom_range(0, V - 1);
         rw = $urandom_range(0, 6);
         rh = $urandom_range(0, 4);
         if (rx + rw > H) rw = H - rx;
         if (ry + rh > V) rh = V - ry;
         send(rx, ry, rw, rh);
         wait_idle();
      end

      // reset in the middle of a 5x5 scan
      rmode = 0;
      send(100, 50, 5, 5);
      repeat (8) @(posedge clock);
      #1;
      check("midscan_valid_before_reset", int'(pix_valid), 1);
      resetn = 1'b0;
      exp_q.delete();
      req_q.delete();
      mon_active = 1'b0;
      stall_prev = 1'b0;
      ready_chk  = -1;
      #1;
      check_reset_outputs("midscan_reset");
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      send(7, 3, 2, 2);
      wait_idle();

      // 640x480 instance: last pixel of the frame
      @(posedge clock);
      #1;
      check("b_start_ready", int'(b_start_ready), 1);
      b_start_valid = 1'b1;
      b_x0 = 10'd639;
      b_y0 = 9'd479;
      b_w  = 10'd1;
      b_h  = 9'd1;
      @(posedge clock);
      #1;
      b_start_valid = 1'b0;
      nb = 0;
      nd = 0;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (b_pix_valid) begin
            nb++;
            check("b_addr", int'(b_pix_addr), 307199);
            check("b_x", int'(b_pix_x), 639);
            check("b_y", int'(b_pix_y), 479);
            check("b_last", int'(b_pix_last), 1);
         end
         if (b_done) nd++;
         if (b_start_ready && nd > 0) ok = 1'b1;
      end
      check("b_beat_count", nb, 1);
      check("b_done_count", nd, 1);
      check("b_back_to_idle", int'(ok), 1);

      check("scoreboard_empty", exp_q.size(), 0);
      check("requests_empty", req_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
